// File: rtl/fb_pkg.sv
// Frame-buffer arbiter shared defaults and the read-return owner encoding.
package fb_pkg;

  localparam int FB_AW         = 18;
  localparam int FB_DW         = 8;
  localparam int FB_STARVE_MAX = 15;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return tag/data pipeline: a read issued in cycle T returns registered data with a one-cycle rvalid at T+2.
// No backpressure: returns are steered to their owner and never collide, since at most one read issues per cycle.
module fb_rd_pipe
  import fb_pkg::*;
#(
  parameter int DW = FB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_vld,
  input  logic          issue_cpu,
  input  logic [DW-1:0] mem_rdata,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata
);

  logic   s1_vld;
  owner_e s1_own;
  logic   s1_vid;
  logic   s1_cpu;

  assign s1_vid = s1_vld && (s1_own == OWN_VID);
  assign s1_cpu = s1_vld && (s1_own == OWN_CPU);

  // Stage 1 lines up with the RAM's registered output; stage 2 is the rvalid/rdata register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld     <= 1'b0;
      s1_own     <= OWN_VID;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      s1_vld     <= issue_vld;
      s1_own     <= issue_cpu ? OWN_CPU : OWN_VID;
      vid_rvalid <= s1_vid;
      cpu_rvalid <= s1_cpu;
      if (s1_vid) vid_rdata <= mem_rdata;
      if (s1_cpu) cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-memory arbiter between video fetch and CPU; grants are combinational, reads return at grant+2.
// Requesters hold their request until granted; nothing is buffered, and the CPU is forced through after STARVE_MAX waits.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int STARVE_MAX = FB_STARVE_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_rvalid,
  input  logic          blank_b,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       cpu_first;

  assign starve_hit = (starve_cnt == STARVE_LIM);
  // CPU wins when starved, during blanking, or when video is not asking.
  assign cpu_first  = starve_hit || !blank_b || !vid_req;

  // Grants are gated by reset so every output reads zero while reset is held.
  assign cpu_gnt = reset && cpu_req && cpu_first;
  assign vid_gnt = reset && vid_req && !cpu_gnt;

  assign mem_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;
  assign mem_we    = cpu_gnt && cpu_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  fb_rd_pipe #(
    .DW(DW)
  ) u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .issue_vld  (vid_gnt || (cpu_gnt && !cpu_we)),
    .issue_cpu  (cpu_gnt),
    .mem_rdata  (mem_rdata),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a cycle-level reference model.
module tb_fb_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int SM = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vid_req = 1'b0;
  logic          blank_b = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          vid_gnt, cpu_gnt, vid_rvalid, cpu_rvalid, mem_we;
  logic [DW-1:0] vid_rdata, cpu_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    int            due;
    bit            cpu;
    logic [DW-1:0] d;
  } ret_t;

  ret_t          ret_q[$];
  int            cyc = 0;
  int            cpu_wait = 0;
  int            nvec = 0;
  int            nerr = 0;
  logic [DW-1:0] exp_vrd = '0;
  logic [DW-1:0] exp_crd = '0;
  bit            obs_vg, obs_cg, m_vg, m_cg;

  fb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .blank_b    (blank_b),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read output.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [13:0] hi;
    hi = ($urandom_range(0, 1) != 0) ? 14'h3FFF : 14'h0000;
    return {hi, 4'($urandom_range(0, 15))};
  endfunction

  // One clock cycle: called at negedge with inputs already driven.
  task automatic step();
    bit   ev, ec;
    ret_t r;
    #1;
    m_vg = 1'b0;
    m_cg = 1'b0;
    if (reset) begin
      if (cpu_req && cpu_wait >= SM) m_cg = 1'b1;
      else if (cpu_req && !blank_b)  m_cg = 1'b1;
      else if (vid_req)              m_vg = 1'b1;
      else if (cpu_req)              m_cg = 1'b1;
    end else begin
      ret_q.delete();
      exp_vrd = '0;
      exp_crd = '0;
    end
    ev = 1'b0;
    ec = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      if (r.cpu) begin ec = 1'b1; exp_crd = r.d; end
      else       begin ev = 1'b1; exp_vrd = r.d; end
    end
    obs_vg = vid_gnt;
    obs_cg = cpu_gnt;
    chk("vid_gnt", vid_gnt, m_vg);
    chk("cpu_gnt", cpu_gnt, m_cg);
    chk("mem_we", mem_we, m_cg && cpu_we);
    chk("mem_addr", mem_addr, m_cg ? 32'(cpu_addr) : (m_vg ? 32'(vid_addr) : 32'd0));
    chk("mem_wdata", mem_wdata, m_cg ? 32'(cpu_wdata) : 32'd0);
    chk("vid_rvalid", vid_rvalid, ev);
    chk("cpu_rvalid", cpu_rvalid, ec);
    chk("vid_rdata", vid_rdata, exp_vrd);
    chk("cpu_rdata", cpu_rdata, exp_crd);
    @(posedge clk);
    if (!reset) begin
      ret_q.delete();
      cpu_wait = 0;
      exp_vrd  = '0;
      exp_crd  = '0;
    end else begin
      if (m_cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else if (m_cg)      ret_q.push_back('{cyc + 2, 1'b1, ref_mem[cpu_addr]});
      if (m_vg)           ret_q.push_back('{cyc + 2, 1'b0, ref_mem[vid_addr]});
      cpu_wait = (cpu_req && !m_cg) ? cpu_wait + 1 : 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = 8'(i + 'h10);
      ref_mem[i] = 8'(i + 'h10);
    end
    @(negedge clk);

    // Reset held with both requests up: everything must stay quiet.
    vid_req = 1'b1;
    cpu_req = 1'b1;
    step();
    step();
    chk("rst_starve_cnt", dut.starve_cnt, 0);

    // Video-only stream, granted in the first cycle after reset release.
    cpu_req = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vid_req  = (i < 4);
      vid_addr = 18'(i);
      step();
      if (i == 0) chk("first_vid_gnt", obs_vg, 1);
      if (i >= 1) begin
        chk("stream_vid_rvalid", vid_rvalid, 1);
        chk("stream_vid_rdata", vid_rdata, 32'h10 + i - 1);
      end
    end
    step();

    // Starvation: CPU must get through on its 16th waiting cycle.
    vid_req  = 1'b1;
    vid_addr = 18'h100;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 18'd5;
    n = 0;
    do begin
      step();
      n++;
    end while (!obs_cg && n < 40);
    chk("starve_gnt_cycle", n, 16);
    chk("starve_vid_gnt", obs_vg, 0);
    cpu_req = 1'b0;
    step();
    chk("starve_cpu_rvalid", cpu_rvalid, 1);
    chk("starve_cpu_rdata", cpu_rdata, 8'h15);
    vid_req = 1'b0;
    step();

    // Blanking: CPU beats video outright.
    blank_b  = 1'b0;
    vid_req  = 1'b1;
    vid_addr = 18'h20;
    cpu_req  = 1'b1;
    cpu_addr = 18'h21;
    step();
    chk("blank_cpu_gnt", obs_cg, 1);
    chk("blank_vid_gnt", obs_vg, 0);
    cpu_req = 1'b0;
    step();
    vid_req = 1'b0;
    blank_b = 1'b1;
    step();
    step();

    // CPU write then video read of the same top address.
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 18'h3FFFF;
    cpu_wdata = 8'hA5;
    step();
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    vid_req  = 1'b1;
    vid_addr = 18'h3FFFF;
    step();
    vid_req = 1'b0;
    step();
    chk("wr_rd_vid_rvalid", vid_rvalid, 1);
    chk("wr_rd_vid_rdata", vid_rdata, 8'hA5);
    chk("wr_no_cpu_rvalid", cpu_rvalid, 0);

    // Reset while a CPU read is in flight.
    cpu_req  = 1'b1;
    cpu_addr = 18'd9;
    step();
    cpu_req = 1'b0;
    vid_req = 1'b1;
    reset   = 1'b0;
    step();
    chk("rst_mid_cpu_rdata", cpu_rdata, 0);
    chk("rst_mid_vid_rdata", vid_rdata, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    step();
    reset   = 1'b1;
    vid_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_drop_cpu_rvalid", cpu_rvalid, 0);
    end

    // Idle.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_starve_cnt", dut.starve_cnt, 0);
      chk("idle_mem_we", mem_we, 0);
    end

    // Randomized traffic with held requests, blanking flips and short resets.
    for (int k = 0; k < 3000; k++) begin
      if (!vid_req && $urandom_range(0, 9) < 7) begin
        vid_req  = 1'b1;
        vid_addr = rnd_addr();
      end
      if (!cpu_req && $urandom_range(0, 9) < 4) begin
        cpu_req   = 1'b1;
        cpu_we    = ($urandom_range(0, 1) != 0);
        cpu_addr  = rnd_addr();
        cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) blank_b = ~blank_b;
      reset = ($urandom_range(0, 149) != 0);
      step();
      if (m_vg) vid_req = 1'b0;
      if (m_cg) cpu_req = 1'b0;
    end
    reset = 1'b1;
    vid_req = 1'b0;
    cpu_req = 1'b0;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter AW, default 18, frame-memory address width.
REQ-002 Parameter DW, default 8, frame-memory data width.
REQ-003 Parameter STARVE_MAX, default 15, maximum CPU wait cycles while video is active.
REQ-004 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 vid_req  in  1  video fetch request; vid_addr  in  AW  video read address.
REQ-007 vid_gnt  out  1  video request accepted this cycle.
REQ-008 vid_rdata  out  DW  video read data; vid_rvalid  out  1  qualifies vid_rdata.
REQ-009 blank_b  in  1  display active-video flag, low during blanking.
REQ-010 cpu_req  in  1  CPU access request; cpu_we  in  1  write enable; cpu_addr  in  AW; cpu_wdata  in  DW.
REQ-011 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-012 cpu_rdata  out  DW  CPU read data; cpu_rvalid  out  1  qualifies cpu_rdata.
REQ-013 mem_addr  out  AW; mem_wdata  out  DW; mem_we  out  1; mem_rdata  in  DW  single-port RAM with registered output, 1-cycle read latency.

Function
REQ-014 At most one of vid_gnt and cpu_gnt SHALL be high in any cycle; a grant SHALL only be issued to a requester whose req is high.
REQ-015 Grants SHALL be combinational from the current req inputs and registered arbiter state; mem_addr, mem_we and mem_wdata SHALL be driven from the granted port in the grant cycle, with mem_we=0 and mem_addr=0 when no grant is issued.
REQ-016 Arbitration priority:
- (a) if starve_cnt equals STARVE_MAX and cpu_req is high, the CPU wins;
- (b) otherwise, if vid_req is high, video wins;
- (c) otherwise, if cpu_req is high, the CPU wins.
REQ-017 While blank_b=0, the CPU SHALL take priority over video.
REQ-018 starve_cnt (4 bits) SHALL behave as follows:
- increment each cycle in which cpu_req=1 and cpu_gnt=0, saturating at STARVE_MAX;
- clear on any cpu_gnt;
- clear when cpu_req=0.
REQ-019 Throughput: one access per cycle, with back-to-back grants permitted in either direction.
REQ-020 Read return: a read granted in cycle T SHALL produce registered rdata and a one-cycle rvalid pulse on the owning port in cycle T+2; writes SHALL produce no rvalid.
REQ-021 The read-return tag pipeline (2 stages: valid bit plus owner bit) SHALL keep ordering; returns for both ports SHALL never collide, because only one grant is issued per cycle.
REQ-022 A CPU write granted in cycle T SHALL be written at T; a read of the same address granted at T+1 SHALL return the new data.
REQ-023 rdata outputs SHALL hold their last value when rvalid=0.
REQ-024 A requester SHALL hold req, addr, we and wdata stable until its gnt; the arbiter SHALL not buffer requests.

Reset
REQ-025 While reset=0, the following SHALL hold, asynchronously:
- vid_gnt=0, cpu_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0;
- vid_rvalid=0, cpu_rvalid=0, vid_rdata=0, cpu_rdata=0;
- starve_cnt=0 and both tag stages invalid.
REQ-026 Reset asserted mid-read SHALL discard in-flight reads, with no rvalid after reset release for reads granted before reset.
REQ-027 The first grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-028 Package fb_pkg SHALL hold AW/DW defaults, STARVE_MAX default and the owner enum (OWN_VID, OWN_CPU).
REQ-029 Sub-module fb_rd_pipe SHALL implement the 2-stage tag/data return pipeline; fb_arbiter SHALL contain the grant logic and starve_cnt.

Verification
REQ-030 Video only:
- stimulus: vid_req=1 constant, blank_b=1, vid_addr 0..3 on consecutive cycles, RAM preloaded mem[i]=i+8'h10;
- response: vid_gnt every cycle; vid_rvalid from grant+2 with vid_rdata 10,11,12,13.
REQ-031 Starvation:
- stimulus: vid_req=1 constant, blank_b=1, cpu_req=1 read at addr 5;
- response: cpu_gnt exactly at the 16th cycle of cpu_req with vid_gnt=0 that cycle; cpu_rvalid 2 cycles later with mem[5].
REQ-032 Blanking:
- stimulus: blank_b=0, vid_req=1 and cpu_req=1 together;
- response: cpu_gnt=1 and vid_gnt=0 in the same cycle.
REQ-033 Write then read:
- stimulus: CPU write 8'hA5 to addr 18'h3FFFF at T, video read of the same address at T+1;
- response: vid_rdata=A5 at T+3, with no cpu_rvalid.
REQ-034 Reset mid-read:
- stimulus: CPU read granted at T, reset=0 at T+1, released at T+3;
- response: cpu_rvalid stays 0 throughout; all outputs read 0 during reset.
REQ-035 Idle:
- stimulus: no requests for 10 cycles;
- response: mem_we=0, both gnt=0, starve_cnt=0.
